// File: rtl/ila_lane_seq_gen.sv
// Per-lane TX octet source feeding the 8b/10b encoder: user data, continuous K28.5,
// or the generated ILA sequence (/R/ ... /A/ multiframes, /Q/ + link config in multiframe 1).
module ila_lane_seq_gen #(
    parameter int F          = 2,
    parameter int K          = 16,
    parameter int CFG_OCTETS = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              i_link_mux,
    input  logic                    i_lmfc_clk,
    input  logic [7:0]              i_ila_multiframe_length,
    input  logic [8*CFG_OCTETS-1:0] i_cfg,
    input  logic [7:0]              i_user_data,
    output logic [7:0]              o_data,
    output logic                    o_is_k,
    output logic                    o_ila_active,
    output logic                    o_ila_done,
    output logic                    o_align_err
);

    localparam int FK = F * K;
    localparam int OW = (FK > 1) ? $clog2(FK) : 1;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_4 = 8'h9C;

    generate
        if (FK < 17) begin : g_bad_fk
            $error("ila_lane_seq_gen: F*K must be >= 17");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE_MUX  = 2'd0,
        WAIT_LMFC = 2'd1,
        ILA       = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [OW-1:0]   oct_idx_reg, oct_idx_next;
    logic [8:0]      mf_idx_reg, mf_idx_next;
    logic [8:0]      ila_len_reg, ila_len_next;
    logic            done_pend_reg, done_pend_next;
    logic            cfg_load;
    logic [7:0]      cfg_reg [CFG_OCTETS];

    logic [7:0]      data_next;
    logic            is_k_next, active_next, done_next, align_err_next;

    logic            mux_ila, mux_user, last_oct;
    logic [7:0]      follow_data, ila_data;
    logic            follow_k, ila_k;

    assign mux_ila     = (i_link_mux == 3'd2);
    assign mux_user    = (i_link_mux == 3'd0);
    assign follow_data = mux_user ? i_user_data : K28_5;
    assign follow_k    = ~mux_user;
    assign last_oct    = (oct_idx_reg == OW'(FK - 1));

    // Config octets are captured once, on the lmfc pulse that starts the ILA.
    generate
        for (genvar gi = 0; gi < CFG_OCTETS; gi++) begin : g_cfg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cfg_reg[gi] <= 8'h00;
                end else if (cfg_load) begin
                    cfg_reg[gi] <= i_cfg[8*gi +: 8];
                end
            end
        end
    endgenerate

    // Octet content for the current (mf_idx, oct_idx) position.
    always_comb begin
        ila_data = 8'(oct_idx_reg);
        ila_k    = 1'b0;
        if (oct_idx_reg == '0) begin
            ila_data = K28_0;
            ila_k    = 1'b1;
        end else if (last_oct) begin
            ila_data = K28_3;
            ila_k    = 1'b1;
        end else if (mf_idx_reg == 9'd1) begin
            if (oct_idx_reg == OW'(1)) begin
                ila_data = K28_4;
                ila_k    = 1'b1;
            end else begin
                for (int c = 0; c < CFG_OCTETS; c++) begin
                    if (oct_idx_reg == OW'(c + 2)) begin
                        ila_data = cfg_reg[c];
                    end
                end
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        oct_idx_next   = oct_idx_reg;
        mf_idx_next    = mf_idx_reg;
        ila_len_next   = ila_len_reg;
        done_pend_next = 1'b0;
        cfg_load       = 1'b0;
        data_next      = follow_data;
        is_k_next      = follow_k;
        active_next    = 1'b0;
        done_next      = 1'b0;
        align_err_next = 1'b0;
        case (state_reg)
            IDLE_MUX: begin
                done_next = done_pend_reg;
                if (mux_ila) begin
                    state_next = WAIT_LMFC;
                end
            end
            WAIT_LMFC: begin
                if (!mux_ila) begin
                    state_next   = IDLE_MUX;
                    oct_idx_next = '0;
                    mf_idx_next  = '0;
                end else if (i_lmfc_clk) begin
                    cfg_load     = 1'b1;
                    ila_len_next = 9'(i_ila_multiframe_length) + 9'd1;
                    oct_idx_next = '0;
                    mf_idx_next  = '0;
                    state_next   = ILA;
                end
            end
            ILA: begin
                if (!mux_ila) begin
                    state_next   = IDLE_MUX;
                    oct_idx_next = '0;
                    mf_idx_next  = '0;
                end else begin
                    data_next   = ila_data;
                    is_k_next   = ila_k;
                    active_next = 1'b1;
                    // Internal count stays authoritative; a stray lmfc is only flagged.
                    align_err_next = i_lmfc_clk & ~last_oct;
                    if (last_oct) begin
                        oct_idx_next = '0;
                        if ((mf_idx_reg + 9'd1) == ila_len_reg) begin
                            mf_idx_next    = '0;
                            done_pend_next = 1'b1;
                            state_next     = IDLE_MUX;
                        end else begin
                            mf_idx_next = mf_idx_reg + 9'd1;
                        end
                    end else begin
                        oct_idx_next = oct_idx_reg + OW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE_MUX;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE_MUX;
            oct_idx_reg   <= '0;
            mf_idx_reg    <= '0;
            ila_len_reg   <= '0;
            done_pend_reg <= 1'b0;
            o_data        <= 8'h00;
            o_is_k        <= 1'b0;
            o_ila_active  <= 1'b0;
            o_ila_done    <= 1'b0;
            o_align_err   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            oct_idx_reg   <= oct_idx_next;
            mf_idx_reg    <= mf_idx_next;
            ila_len_reg   <= ila_len_next;
            done_pend_reg <= done_pend_next;
            o_data        <= data_next;
            o_is_k        <= is_k_next;
            o_ila_active  <= active_next;
            o_ila_done    <= done_next;
            o_align_err   <= align_err_next;
        end
    end

endmodule
